// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: PC-source select encodings, default NOP encoding and
// the fetch FSM state type.
package pipeline_pkg;

  localparam logic [1:0] CSEL_SEQ  = 2'b00;
  localparam logic [1:0] CSEL_BRA  = 2'b01;
  localparam logic [1:0] CSEL_RAA  = 2'b10;
  localparam logic [1:0] CSEL_BRA2 = 2'b11;

  localparam logic [31:0] NOP_IR_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDrop,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {ir, pc} holding buffer between the imem response and the IF/ID register.
// Flush has priority over push; push and pop never coincide in the fetch stage.
module if_skid_buf #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   push_ir,
  input  logic [AW-1:0] push_pc,
  output logic          full,
  output logic [31:0]   pop_ir,
  output logic [AW-1:0] pop_pc
);

  logic          full_q;
  logic [31:0]   ir_q;
  logic [AW-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      ir_q   <= '0;
      pc_q   <= '0;
    end else if (flush) begin
      full_q <= 1'b0;
    end else if (push) begin
      full_q <= 1'b1;
      ir_q   <= push_ir;
      pc_q   <= push_pc;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  assign full   = full_q;
  assign pop_ir = ir_q;
  assign pop_pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: fetch PC, single-outstanding imem request FSM, redirect handling and IF/ID register.
// Defining IF_PERF_CNT_EN adds the perf_fetch_cnt / perf_flush_cnt event counters.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [31:0]   NOP_IR   = NOP_IR_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_i,
  input  logic [1:0]    c_select,
  input  logic [AW-1:0] bra,
  input  logic [AW-1:0] raa,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          id_valid,
  output logic [31:0]   id_ir,
  output logic [AW-1:0] id_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_flush_cnt
`endif
);

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic [AW-1:0] target;
  logic          redirect;
  logic          deliver;
  logic          id_load;

  logic          skid_push, skid_pop, skid_full;
  logic [31:0]   skid_ir;
  logic [AW-1:0] skid_pc;

  logic          id_valid_q;
  logic [31:0]   id_ir_q;
  logic [AW-1:0] id_pc_q;

  assign redirect = (c_select != CSEL_SEQ);

  always_comb begin
    target = fetch_pc_q;
    case (c_select)
      CSEL_BRA, CSEL_BRA2: target = bra;
      CSEL_RAA:            target = raa;
      default:             target = fetch_pc_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    deliver    = 1'b0;
    case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_ONE;
          // A redirect in the grant cycle still leaves a response to swallow.
          state_d    = redirect ? StDrop : StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          if (!redirect) begin
            deliver = 1'b1;
            state_d = stall_i ? StHold : StReq;
          end else begin
            state_d = StReq;
          end
        end else if (redirect) begin
          state_d = StDrop;
        end
      end
      StDrop: if (imem_rvalid) state_d = StReq;
      StHold: if (!stall_i) state_d = StReq;
      default: state_d = StIdle;
    endcase
    if (redirect) begin
      fetch_pc_d = target;
      // The skid is flushed by the redirect, so HOLD has nothing left to wait for.
      if (state_q == StHold) state_d = StReq;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign imem_req  = (state_q == StReq);
  assign imem_addr = fetch_pc_q;

  // While ID stalls, fresh data parks in the skid so IF/ID stays untouched.
  assign skid_push = deliver && stall_i;
  assign skid_pop  = skid_full && !stall_i && !redirect;
  assign id_load   = !redirect && !stall_i && (skid_full || deliver);

  if_skid_buf #(
    .AW (AW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (skid_push),
    .pop     (skid_pop),
    .flush   (redirect),
    .push_ir (imem_rdata),
    .push_pc (req_pc_q),
    .full    (skid_full),
    .pop_ir  (skid_ir),
    .pop_pc  (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_ir_q    <= NOP_IR;
      id_pc_q    <= '0;
    end else if (redirect) begin
      id_valid_q <= 1'b0;
      id_ir_q    <= NOP_IR;
    end else if (!stall_i) begin
      if (id_load) begin
        id_valid_q <= 1'b1;
        id_ir_q    <= skid_full ? skid_ir : imem_rdata;
        id_pc_q    <= skid_full ? skid_pc : req_pc_q;
      end else begin
        id_valid_q <= 1'b0;
        id_ir_q    <= NOP_IR;
      end
    end
  end

  assign id_valid = id_valid_q;
  assign id_ir    = id_ir_q;
  assign id_pc    = id_pc_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (id_load)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run checked
// against an in-order instruction-stream model and an imem protocol monitor.
module tb_fetch_stage;

  localparam int unsigned AW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          stall_i;
  logic [1:0]    c_select;
  logic [AW-1:0] bra, raa;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          id_valid;
  logic [31:0]   id_ir;
  logic [AW-1:0] id_pc;

  // Second instance: 8-bit PC starting at the top of the address space.
  logic          w_req, w_rvalid = 1'b0, w_pend = 1'b0, w_id_valid;
  logic [7:0]    w_addr, w_id_pc;
  logic [31:0]   w_rdata = '0, w_pend_addr = '0, w_id_ir;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, w_perf_fetch, w_perf_flush;
`endif

  fetch_stage #(.AW(AW), .RESET_PC(32'd0), .NOP_IR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .c_select(c_select), .bra(bra), .raa(raa),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ir(id_ir), .id_pc(id_pc)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  fetch_stage #(.AW(8), .RESET_PC(8'hFF), .NOP_IR(NOP)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall_i(1'b0), .c_select(2'b00), .bra(8'h00), .raa(8'h00),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .id_valid(w_id_valid), .id_ir(w_id_ir), .id_pc(w_id_pc)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(w_perf_fetch), .perf_flush_cnt(w_perf_flush)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory behaviour knobs, set by the scenario tasks.
  int gnt_block = 0;
  bit gnt_rand  = 0;
  bit rv_rand   = 0;
  int rv_lat    = 0;

  logic          pend = 1'b0, had_pend;
  int            pend_wait = 0;
  logic [AW-1:0] pend_addr = '0;
  int            gnt_count = 0;

  // Reference model: the accepted instruction stream is exp_pc, exp_pc+1, ... restarting
  // at the target of every redirect; mem[a] = a + 100.
  logic [AW-1:0] exp_pc = '0;
  int            accepted = 0, redirects = 0, flushed_valid = 0;
  logic          prev_req = 1'b0, prev_gnt = 1'b0, prev_redir = 1'b0;
  logic [AW-1:0] prev_addr = '0, prev_tgt = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; gnt_count = 0;
      exp_pc = '0; accepted = 0; redirects = 0; flushed_valid = 0;
      prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0;
      w_pend = 1'b0; w_rvalid = 1'b0;
    end else begin
      w_rvalid    = w_pend;
      w_rdata     = w_pend_addr + 32'd100;
      w_pend      = w_req;
      w_pend_addr = {24'h0, w_addr};

      had_pend    = pend;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) begin
        if (pend_wait == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pend_addr + 32'd100;
          pend        = 1'b0;
        end else begin
          pend_wait--;
        end
      end
      imem_gnt = 1'b0;
      if (imem_req === 1'b1) begin
        if (gnt_block > 0) gnt_block--;
        else if (!gnt_rand || $urandom_range(0, 1) == 1) begin
          imem_gnt  = 1'b1;
          pend      = 1'b1;
          pend_addr = imem_addr;
          pend_wait = rv_rand ? int'($urandom_range(0, 2)) : rv_lat;
          gnt_count++;
        end
      end

      n_checks++;
      if (imem_req !== 1'b0 && had_pend) begin
        n_fail++; $display("FAIL one_outstanding: req=%b while a response is pending", imem_req);
      end
      if (id_valid === 1'b0) begin
        n_checks++;
        if (id_ir !== NOP) begin
          n_fail++; $display("FAIL nop_when_invalid: id_ir=%h want %h", id_ir, NOP);
        end
      end
      if (id_valid !== 1'b0 && !stall_i) begin
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== exp_pc || id_ir !== exp_pc + 32'd100) begin
          n_fail++;
          $display("FAIL stream_order: valid=%b pc=%h ir=%h want pc=%h ir=%h",
                   id_valid, id_pc, id_ir, exp_pc, exp_pc + 32'd100);
        end
        exp_pc = exp_pc + 1;
        accepted++;
      end
      if (prev_req && !prev_gnt && !prev_redir) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL req_hold: req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, prev_addr);
        end
      end
      if (prev_redir && imem_req === 1'b1) begin
        n_checks++;
        if (imem_addr !== prev_tgt) begin
          n_fail++; $display("FAIL redirect_addr: addr=%h want %h", imem_addr, prev_tgt);
        end
      end

      prev_redir = (c_select != 2'b00);
      prev_tgt   = (c_select == 2'b10) ? raa : bra;
      if (prev_redir) begin
        if (id_valid === 1'b1 && stall_i) flushed_valid++;
        redirects++;
        exp_pc = prev_tgt;
      end
      prev_req  = (imem_req === 1'b1);
      prev_gnt  = imem_gnt;
      prev_addr = imem_addr;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall_i = 1'b0; c_select = 2'b00; bra = '0; raa = '0;
    gnt_block = 0; gnt_rand = 0; rv_rand = 0; rv_lat = 0;
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; c_select = 2'b00;
    gnt_block = 0; gnt_rand = 0; rv_rand = 0; rv_lat = 0;
    repeat (2) cyc();
    n_checks++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_ir !== NOP || id_pc !== '0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b valid=%b ir=%h pc=%h want 0 0 %h 0",
               imem_req, id_valid, id_ir, id_pc, NOP);
    end
    n_checks++;
    if (w_req !== 1'b0 || w_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_wrap: req=%b valid=%b want 0 0", w_req, w_id_valid);
    end
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0 || w_req !== 1'b1 || w_addr !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%b addr=%h wreq=%b waddr=%h want 1 0 1 ff",
               imem_req, imem_addr, w_req, w_addr);
    end
  endtask

  task automatic test_stream();
    logic          exp_v;
    logic [AW-1:0] e_pc;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc();
      exp_v = (k >= 2) && (k % 2 == 0);
      e_pc  = (k - 2) / 2;
      n_checks++;
      if (id_valid !== exp_v || (exp_v && (id_pc !== e_pc || id_ir !== e_pc + 32'd100))) begin
        n_fail++;
        $display("FAIL stream k=%0d: valid=%b pc=%h ir=%h want valid=%b pc=%h ir=%h",
                 k, id_valid, id_pc, id_ir, exp_v, e_pc, e_pc + 32'd100);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (k >= 2 && k <= 8) begin
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'd0 || id_ir !== 32'd100) begin
          n_fail++; $display("FAIL stall_frozen k=%0d: valid=%b pc=%h ir=%h want 1 0 64",
                             k, id_valid, id_pc, id_ir);
        end
      end
      if (k >= 4 && k <= 8) begin
        n_checks++;
        if (imem_req !== 1'b0) begin
          n_fail++; $display("FAIL stall_no_req k=%0d: req=%b want 0", k, imem_req);
        end
      end
      if (k == 9 || k == 11) begin
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== AW'((k - 7) / 2) || id_ir !== 32'((k - 7) / 2 + 100)) begin
          n_fail++; $display("FAIL stall_release k=%0d: valid=%b pc=%h ir=%h want pc=%0d",
                             k, id_valid, id_pc, id_ir, (k - 7) / 2);
        end
      end
      if (k == 9) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd2) begin
          n_fail++; $display("FAIL stall_resume_req: req=%b addr=%h want 1 2", imem_req, imem_addr);
        end
      end
      stall_i = (k >= 2 && k <= 7);
    end
    stall_i = 1'b0;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    rv_lat = 2;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k >= 2 && k <= 5) begin
        n_checks++;
        if (id_valid !== 1'b0) begin
          n_fail++; $display("FAIL redir_wait_bubble k=%0d: valid=%b want 0", k, id_valid);
        end
      end
      if (k == 3) begin
        n_checks++;
        if (imem_req !== 1'b0) begin
          n_fail++; $display("FAIL redir_wait_drop: req=%b want 0", imem_req);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
          n_fail++; $display("FAIL redir_wait_addr: req=%b addr=%h want 1 40", imem_req, imem_addr);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_ir !== 32'hA4) begin
          n_fail++; $display("FAIL redir_wait_target: valid=%b pc=%h ir=%h want 1 40 a4",
                             id_valid, id_pc, id_ir);
        end
      end
      if (k == 1) begin c_select = 2'b01; bra = 32'h40; end
      if (k == 2) begin c_select = 2'b00; rv_lat = 0; end
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k == 5) begin
        n_checks++;
        if (id_valid !== 1'b1 || imem_req !== 1'b0) begin
          n_fail++; $display("FAIL redir_stall_pre: valid=%b req=%b want 1 0", id_valid, imem_req);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (id_valid !== 1'b0 || id_ir !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
          n_fail++; $display("FAIL redir_stall_flush: valid=%b ir=%h req=%b addr=%h want 0 %h 1 80",
                             id_valid, id_ir, imem_req, imem_addr, NOP);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (id_valid !== 1'b0) begin
          n_fail++; $display("FAIL redir_stall_skid_empty: valid=%b pc=%h want 0", id_valid, id_pc);
        end
      end
      if (k == 8) begin
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h80 || id_ir !== 32'hE4) begin
          n_fail++; $display("FAIL redir_stall_target: valid=%b pc=%h ir=%h want 1 80 e4",
                             id_valid, id_pc, id_ir);
        end
      end
      if (k == 2) stall_i = 1'b1;
      if (k == 5) begin c_select = 2'b10; raa = 32'h80; end
      if (k == 6) begin c_select = 2'b00; stall_i = 1'b0; end
    end
  endtask

  task automatic test_gnt_hold();
    do_reset();
    gnt_block = 5;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k <= 5) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== ((k <= 2) ? 32'h0 : 32'h10)) begin
          n_fail++; $display("FAIL gnt_hold k=%0d: req=%b addr=%h want 1 %h",
                             k, imem_req, imem_addr, (k <= 2) ? 32'h0 : 32'h10);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_ir !== 32'h74 || gnt_count != 1) begin
          n_fail++; $display("FAIL gnt_hold_result: valid=%b pc=%h ir=%h grants=%0d want 1 10 74 1",
                             id_valid, id_pc, id_ir, gnt_count);
        end
      end
      if (k == 2) begin c_select = 2'b01; bra = 32'h10; end
      if (k == 3) c_select = 2'b00;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (k >= 2 && k % 2 == 0) begin
        n_checks++;
        if (w_id_valid !== 1'b1 || w_id_pc !== 8'(8'hFF + (k - 2) / 2) ||
            w_id_ir !== 32'(8'(8'hFF + (k - 2) / 2)) + 32'd100) begin
          n_fail++; $display("FAIL wrap k=%0d: valid=%b pc=%h ir=%h want pc=%h",
                             k, w_id_valid, w_id_pc, w_id_ir, 8'(8'hFF + (k - 2) / 2));
        end
      end
    end
`ifdef IF_PERF_CNT_EN
    n_checks++;
    if (w_perf_fetch !== 32'd3 || w_perf_flush !== 32'd0) begin
      n_fail++; $display("FAIL wrap_perf: fetch=%0d flush=%0d want 3 0", w_perf_fetch, w_perf_flush);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    gnt_rand = 1; rv_rand = 1;
    for (int k = 0; k < 600; k++) begin
      cyc();
      stall_i = ($urandom_range(0, 9) < 3);
      if (c_select != 2'b00) c_select = 2'b00;
      else if ($urandom_range(0, 19) == 0) begin
        c_select = 2'($urandom_range(1, 3));
        bra = $urandom;
        raa = $urandom;
      end
    end
    stall_i = 1'b0; c_select = 2'b00;
    cyc();
    n_checks++;
    if (accepted < 30) begin
      n_fail++; $display("FAIL random_progress: accepted=%0d want >=30", accepted);
    end
`ifdef IF_PERF_CNT_EN
    n_checks++;
    if (perf_flush_cnt !== 32'(redirects)) begin
      n_fail++; $display("FAIL perf_flush: got %0d want %0d", perf_flush_cnt, redirects);
    end
    n_checks++;
    if (perf_fetch_cnt !== 32'(accepted + flushed_valid + ((id_valid === 1'b1) ? 1 : 0))) begin
      n_fail++; $display("FAIL perf_fetch: got %0d want %0d", perf_fetch_cnt,
                         accepted + flushed_valid + ((id_valid === 1'b1) ? 1 : 0));
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; c_select = 2'b00; bra = '0; raa = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_gnt_hold();
    test_wrap();
    test_random();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
